// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared FSM encoding and default timing constants for the tone sequencer
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  // Defaults target a 50 MHz clock with 1 ms duration ticks.
  localparam int DEF_CNT_W    = 15;
  localparam int DEF_DUR_W    = 12;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_TICK_DIV = 50000;

endpackage

// File: rtl/note_fifo.sv
// rtl/note_fifo.sv - show-ahead synchronous note FIFO with flush and occupancy count
module note_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - queued square-wave note player with rests, pause, flush and completion pulses
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DUR_W    = DEF_DUR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   note_valid,
  output logic                   note_ready,
  input  logic [CNT_W-1:0]       note_half_period,
  input  logic [DUR_W-1:0]       note_duration,
  output logic                   sound,
  output logic                   busy,
  output logic                   note_done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int WIDTH = CNT_W + DUR_W;
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cur_hp;
  logic [DUR_W-1:0] cur_dur;
  logic [CNT_W-1:0] per_cnt;
  logic [TW-1:0]    tick_cnt;
  logic             snd;

  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CNT_W-1:0] head_hp;
  logic [DUR_W-1:0] head_dur;

  logic             load_note;
  logic             advance;
  logic             tick_wrap;
  logic             per_wrap;

  assign note_ready = !fifo_full && !flush;
  assign fifo_push  = note_valid && note_ready;
  assign head_hp    = fifo_dout[WIDTH-1:DUR_W];
  assign head_dur   = fifo_dout[DUR_W-1:0];

  note_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_note_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   ({note_half_period, note_duration}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tick_wrap = (tick_cnt == TICK_LAST);
  // Only evaluated while cur_hp is non-zero, so cur_hp-1 never underflows.
  assign per_wrap  = (per_cnt == (cur_hp - CNT_W'(1)));

  assign sound = snd & enable & (state == ST_PLAY) & (cur_hp != '0);
  assign busy  = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Pause freezes every transition; flush overrides everything including a note end.
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    load_note  = 1'b0;
    advance    = 1'b0;
    note_done  = 1'b0;
    if (flush) begin
      next_state = ST_IDLE;
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            next_state = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (fifo_empty) begin
            next_state = ST_IDLE;
          end else begin
            fifo_pop  = 1'b1;
            load_note = 1'b1;
            if (head_dur == '0) begin
              note_done  = 1'b1;
              next_state = ST_IDLE;
            end else begin
              next_state = ST_PLAY;
            end
          end
        end
        ST_PLAY: begin
          advance = 1'b1;
          if (tick_wrap && (cur_dur == DUR_W'(1))) begin
            note_done  = 1'b1;
            next_state = fifo_empty ? ST_IDLE : ST_LOAD;
          end
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_hp   <= '0;
      cur_dur  <= '0;
      per_cnt  <= '0;
      tick_cnt <= '0;
      snd      <= 1'b0;
    end else if (flush) begin
      cur_hp   <= '0;
      cur_dur  <= '0;
      per_cnt  <= '0;
      tick_cnt <= '0;
      snd      <= 1'b0;
    end else if (load_note) begin
      cur_hp   <= head_hp;
      cur_dur  <= head_dur;
      per_cnt  <= '0;
      tick_cnt <= '0;
      snd      <= 1'b0;
    end else if (advance) begin
      if (cur_hp != '0) begin
        if (per_wrap) begin
          per_cnt <= '0;
          snd     <= ~snd;
        end else begin
          per_cnt <= per_cnt + CNT_W'(1);
        end
      end
      if (tick_wrap) begin
        tick_cnt <= '0;
        cur_dur  <= cur_dur - DUR_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Parametrised successor to the single-tone square-wave speaker driver. Accepts a queue of notes (half-period, duration) over a valid/ready handshake. Plays them back-to-back as a gated square wave, with rests, pause, flush and per-note completion pulses. Sits between the game-logic sound controller and the speaker pin, replacing the free-running single-tone generator.

Parameters:
CNT_W, 15, width of note half-period in clk cycles (max 2^CNT_W-1)
DUR_W, 12, width of note duration in ticks
DEPTH, 4, note FIFO depth; power of two, >=2
TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = play; 0 = pause (all counters hold, sound forced 0)
flush  in  1  1-cycle request: empty FIFO and abort current note
note_valid  in  1  note offered
note_ready  out  1  FIFO can accept: !full && !flush
note_half_period  in  CNT_W  square-wave half period in clk cycles; 0 = rest
note_duration  in  DUR_W  note length in ticks; 0 = skip
sound  out  1  square-wave output to speaker
busy  out  1  1 when state != IDLE or FIFO not empty
note_done  out  1  1-cycle pulse when a note finishes normally
fifo_count  out  $clog2(DEPTH)+1  notes currently queued

Behaviour:
- Reset (async, immediate): FIFO empty, state IDLE, all counters 0, snd 0. Outputs sound=0, busy=0, note_done=0, fifo_count=0. note_ready=1 after reset deasserts.
- Push occurs when note_valid && note_ready at a clk edge. Pushes while full are impossible because note_ready=0. Simultaneous push and pop are allowed: fifo_count is unchanged.
- FSM:
  - IDLE: if FIFO not empty -> LOAD.
  - LOAD: pop head into cur_hp/cur_dur. Clear the period counter, tick prescaler and snd. If cur_dur==0, pulse note_done and go to IDLE; otherwise go to PLAY.
  - PLAY: when enable=1, advance the counters below. When the note ends, pulse note_done. Then go to LOAD if the FIFO is not empty (back-to-back, no gap cycle beyond LOAD), else IDLE.
- Latency: push to an empty FIFO in IDLE at edge N -> LOAD at N+1 -> PLAY at N+2.
- Period counter (PLAY, enable=1, cur_hp!=0): counts 0..cur_hp-1. On reaching cur_hp-1 it wraps to 0 and toggles snd. High and low phases are each exactly cur_hp cycles. Full period = 2*cur_hp.
- Tick prescaler (PLAY, enable=1): counts 0..TICK_DIV-1 and wraps. On wrap, remaining duration decrements. The note ends on the wrap that takes remaining from 1 to 0. A note of D ticks therefore lasts D*TICK_DIV enabled PLAY cycles.
- sound = snd & enable & (state==PLAY) & (cur_hp!=0). Combinational from registers; no glitch on the enable path in the target flow.
- Rest (hp=0): the duration counts normally and sound stays 0.
- Pause: enable=0 freezes the period counter, prescaler, duration and FSM. IDLE->LOAD and LOAD also hold. Pushes are still accepted. Resuming continues mid-phase with no restart.
- Flush: at that edge the FIFO is emptied, state -> IDLE, counters and snd cleared, no note_done. A same-cycle push is dropped because note_ready=0. Flush has priority over note end.
- Width rules: all counters are unsigned. Comparisons are at full width; no truncation of cur_hp-1 because cur_hp>=1 is guaranteed when used.
- Boundary cases:
  - hp=1 toggles every cycle, giving clk/2.
  - hp=2^CNT_W-1 is legal.
  - dur=2^DUR_W-1 is legal.
  - FIFO full with a pop the same cycle: note_ready is still 0 that cycle (registered full).

Decomposition:
- Shared header/package tone_pkg: FSM state encodings (IDLE, LOAD, PLAY) and default parameter constants (CNT_W, DUR_W, TICK_DIV for 50 MHz).
- One natural sub-module: note_fifo. It is a synchronous FIFO with parameters WIDTH=CNT_W+DUR_W and DEPTH, and ports push, pop, flush, din, dout, full, empty, count. Same async active-high reset.
- tone_sequencer holds the FSM, period counter, prescaler and duration counter.

Test Plan:
- Bench settings TICK_DIV=4, DEPTH=4. Push {hp=3, dur=2}, enable=1 -> LOAD at +1, PLAY at +2. sound is 0 for 3 cycles, high for 3, low for 2 (note ends after 8 cycles). note_done pulses once; busy falls after.
- Push {hp=2,dur=1}, {hp=0,dur=2}, {hp=1,dur=1} back-to-back -> sound toggles every 2 cycles for 4 cycles. Then 8 cycles of silence (rest). Then toggles every cycle for 4 cycles. Three note_done pulses, each exactly one LOAD cycle apart from the next note.
- Push 5 notes with dur=3, continuous valid -> note_ready drops after 4 accepted (fifo_count=4). The 5th is accepted on the first pop cycle+1, and fifo_count never exceeds 4.
- Mid-note of {hp=5,dur=4}, drive enable=0 for 7 cycles -> sound=0 and all counters frozen. On resume the remaining phase and duration continue exactly, so total PLAY length is still 16 enabled cycles.
- With 3 notes queued and one playing, pulse flush together with note_valid -> next cycle: state IDLE, fifo_count=0, sound=0, no note_done, and the concurrent push not stored.
- Assert reset mid-PLAY asynchronously between clk edges -> sound, busy and fifo_count go to 0 immediately. Push {hp=4,dur=0} after release -> note_done pulses in LOAD with no sound and no PLAY state.
